// File: rtl/neg_accum.sv
// Purpose : saturating signed accumulator over a burst of N_SAMPLES 4-bit two's-complement samples.
// Latency : 1 cycle from start to in_ready; result valid 1 cycle after the last accept (N_SAMPLES+1 cycles with no stalls).
// Backpressure: in_valid=0 stalls the burst; out_ready=0 holds acc_out/sat/out_valid stable in DONE.
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   start                - begin a burst (only honoured in IDLE)
//   in_valid/in_ready    - sample handshake, in_data is a signed 4-bit value
//   out_valid/out_ready  - result handshake, acc_out is the signed sum, sat is sticky saturation
module neg_accum #(
  parameter int N_SAMPLES = 4,
  parameter int ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Clamp limits expressed at ACC_W+1 bits so the unclamped sum can be compared directly.
  localparam logic signed [ACC_W:0] ACC_MAX = $signed({2'b00, {(ACC_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] ACC_MIN = $signed({2'b11, {(ACC_W-1){1'b0}}});
  localparam logic [7:0]            LAST    = 8'(N_SAMPLES - 1);

  state_t                 state, state_nxt;
  logic [7:0]             count, count_nxt;
  logic [ACC_W-1:0]       acc_nxt;
  logic                   sat_nxt;
  logic signed [ACC_W:0]  sum;
  logic                   accept;

  assign accept = in_ready && in_valid;

  // One guard bit above the accumulator is enough: |sample| <= 8 cannot overflow ACC_W+1 bits.
  assign sum = $signed({acc_out[ACC_W-1], acc_out}) +
               $signed({{(ACC_W-3){in_data[3]}}, in_data});

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    acc_nxt   = acc_out;
    sat_nxt   = sat;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACC;
          count_nxt = 8'd0;
          acc_nxt   = '0;
          sat_nxt   = 1'b0;
        end
      end
      ACC: begin
        if (accept) begin
          if (sum > ACC_MAX) begin
            acc_nxt = ACC_MAX[ACC_W-1:0];
            sat_nxt = 1'b1;
          end else if (sum < ACC_MIN) begin
            acc_nxt = ACC_MIN[ACC_W-1:0];
            sat_nxt = 1'b1;
          end else begin
            acc_nxt = sum[ACC_W-1:0];
          end
          count_nxt = count + 8'd1;
          if (count == LAST) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        // start in the handshake cycle is dropped: we only look at start while in IDLE.
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= 8'd0;
      acc_out   <= '0;
      sat       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      acc_out   <= acc_nxt;
      sat       <= sat_nxt;
      // Flopped decodes of the next state keep in_valid/out_ready off the handshake outputs.
      in_ready  <= (state_nxt == ACC);
      out_valid <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_neg_accum.sv
module tb_neg_accum;

  typedef struct packed {
    logic [7:0] acc;
    logic       sat;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] start;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;
  logic [2:0] in_ready;
  logic [2:0] out_valid;
  logic [7:0] acc_out [3];
  logic [2:0] sat;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int total = 0;
  int bad   = 0;

  // Instance 0: N=4, instance 1: N=20, instance 2: N=1.
  neg_accum #(.N_SAMPLES(4), .ACC_W(8)) u_n4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready),
    .acc_out(acc_out[0]), .sat(sat[0]));

  neg_accum #(.N_SAMPLES(20), .ACC_W(8)) u_n20 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready),
    .acc_out(acc_out[1]), .sat(sat[1]));

  neg_accum #(.N_SAMPLES(1), .ACC_W(8)) u_n1 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_ready(out_ready),
    .acc_out(acc_out[2]), .sat(sat[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [7:0] a, input logic s);
    exp_t e;
    e.acc = a;
    e.sat = s;
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Scoreboard monitor: compare whenever a result handshake is about to complete.
  task automatic check_out(input int k);
    exp_t e;
    int   n;
    n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    total++;
    if (n == 0) begin
      bad++;
      $display("FAIL unexpected_result inst%0d: got acc=%h sat=%b with nothing expected", k, acc_out[k], sat[k]);
    end else begin
      case (k)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      if (acc_out[k] !== e.acc || sat[k] !== e.sat) begin
        bad++;
        $display("FAIL result inst%0d: got acc=%h sat=%b expected acc=%h sat=%b",
                 k, acc_out[k], sat[k], e.acc, e.sat);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_ready) begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k]) check_out(k);
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input int k);
    start[k] = 1'b1;
    cyc(1);
    start[k] = 1'b0;
  endtask

  // Offer one sample and return 1 step after the accepting edge.
  task automatic send(input int k, input logic [3:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready[k] && n < 100) begin
      cyc(1);
      n++;
    end
    if (n == 100) begin
      total++;
      bad++;
      $display("FAIL send_timeout inst%0d: in_ready stayed 0 expected 1", k);
    end
    cyc(1);
    in_valid = 1'b0;
  endtask

  // Hold backpressure for 'hold' cycles checking stability, then complete the handshake.
  task automatic drain(input int k, input int hold, input logic [7:0] exp_acc);
    int n;
    n = 0;
    while (!out_valid[k] && n < 100) begin
      cyc(1);
      n++;
    end
    if (n == 100) begin
      total++;
      bad++;
      $display("FAIL out_valid_timeout inst%0d: out_valid stayed 0 expected 1", k);
    end
    for (int i = 0; i < hold; i++) begin
      chk("hold_acc", acc_out[k], exp_acc);
      chk("hold_valid", {7'd0, out_valid[k]}, 8'd1);
      cyc(1);
    end
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk("idle_after_rdy", {7'd0, out_valid[k]}, 8'd0);
    chk("in_ready_idle", {7'd0, in_ready[k]}, 8'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 3'b000;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    out_ready = 1'b0;
    cyc(2);
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", {7'd0, in_ready[k]}, 8'd0);
      chk("rst_out_valid", {7'd0, out_valid[k]}, 8'd0);
      chk("rst_acc", acc_out[k], 8'h00);
      chk("rst_sat", {7'd0, sat[k]}, 8'd0);
    end
    rst_n = 1'b1;
    cyc(2);

    // Reset in mid-burst after two accepts.
    do_start(0);
    chk("rdy_after_start", {7'd0, in_ready[0]}, 8'd1);
    send(0, 4'd3);
    send(0, 4'd2);
    chk("acc_mid_burst", acc_out[0], 8'h05);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {7'd0, in_ready[0]}, 8'd0);
    chk("mid_rst_out_valid", {7'd0, out_valid[0]}, 8'd0);
    chk("mid_rst_acc", acc_out[0], 8'h00);
    chk("mid_rst_sat", {7'd0, sat[0]}, 8'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    chk("post_rst_idle", {7'd0, in_ready[0]}, 8'd0);
    // Clean burst after reset: 1+2+3-1 = 5.
    push(0, 8'h05, 1'b0);
    do_start(0);
    send(0, 4'd1);
    send(0, 4'd2);
    send(0, 4'd3);
    send(0, 4'hF);
    drain(0, 0, 8'h05);

    // Negative sum, back-to-back: 4 x -1 = -4.
    push(0, 8'hFC, 1'b0);
    do_start(0);
    send(0, 4'hF);
    send(0, 4'hF);
    send(0, 4'hF);
    chk("ov_before_last", {7'd0, out_valid[0]}, 8'd0);
    send(0, 4'hF);
    chk("ov_latency", {7'd0, out_valid[0]}, 8'd1);
    chk("rdy_fall", {7'd0, in_ready[0]}, 8'd0);
    drain(0, 0, 8'hFC);

    // Stalls and backpressure: 7-8+3-2 = 0, intermediate 7,-1,2.
    push(0, 8'h00, 1'b0);
    do_start(0);
    send(0, 4'd7);
    cyc(3);
    chk("stall_acc1", acc_out[0], 8'h07);
    send(0, 4'h8);
    cyc(3);
    chk("stall_acc2", acc_out[0], 8'hFF);
    send(0, 4'd3);
    cyc(3);
    chk("stall_acc3", acc_out[0], 8'h02);
    send(0, 4'hE);
    drain(0, 5, 8'h00);

    // Positive saturation: 18*7=126, 19th clamps to 127.
    push(1, 8'h7F, 1'b1);
    do_start(1);
    for (int i = 0; i < 20; i++) send(1, 4'd7);
    drain(1, 1, 8'h7F);
    // Clamp then -1 continues from 127 -> 126, sat stays.
    push(1, 8'h7E, 1'b1);
    do_start(1);
    for (int i = 0; i < 19; i++) send(1, 4'd7);
    send(1, 4'hF);
    drain(1, 1, 8'h7E);

    // Negative saturation: 16*-8 = -128, then held at the floor.
    push(1, 8'h80, 1'b1);
    do_start(1);
    for (int i = 0; i < 20; i++) send(1, 4'h8);
    drain(1, 1, 8'h80);

    // Ignored inputs: start during ACC, start and in_valid during DONE.
    push(0, 8'h04, 1'b0);
    do_start(0);
    send(0, 4'd1);
    send(0, 4'd1);
    do_start(0);
    chk("start_in_acc", acc_out[0], 8'h02);
    send(0, 4'd1);
    send(0, 4'd1);
    chk("ov_count_intact", {7'd0, out_valid[0]}, 8'd1);
    start[0] = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'd5;
    cyc(3);
    start[0] = 1'b0;
    in_valid = 1'b0;
    chk("done_acc_hold", acc_out[0], 8'h04);
    chk("done_no_ready", {7'd0, in_ready[0]}, 8'd0);
    // start coincident with the out_ready handshake is dropped.
    start[0] = 1'b1;
    drain(0, 0, 8'h04);
    start[0] = 1'b0;
    cyc(1);
    chk("start_at_hs_ignored", {7'd0, in_ready[0]}, 8'd0);
    in_valid = 1'b1;
    in_data  = 4'd7;
    cyc(3);
    in_valid = 1'b0;
    chk("idle_acc_kept", acc_out[0], 8'h04);
    chk("idle_no_accept", {7'd0, in_ready[0]}, 8'd0);

    // Single-sample burst: -6.
    push(2, 8'hFA, 1'b0);
    do_start(2);
    send(2, 4'b1010);
    chk("n1_ov_latency", {7'd0, out_valid[2]}, 8'd1);
    drain(2, 0, 8'hFA);

    cyc(3);
    chk("q0_empty", 8'(q0.size()), 8'd0);
    chk("q1_empty", 8'(q1.size()), 8'd0);
    chk("q2_empty", 8'(q2.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neg_accum.md
# neg_accum

Downstream consumer of the 4-bit two's-complement negator stage. Accepts a burst of N_SAMPLES signed 4-bit values over a valid/ready handshake, sign-extends each to ACC_W bits, and sums them into a saturating accumulator. After the last sample it presents the sum and a sticky saturation flag on an output handshake, then returns to idle. This block turns the negator's per-value results into a running signed total for the datapath that follows.

## Interface
- N_SAMPLES, default 4: samples per burst; legal range 1..255.
- ACC_W, default 8: accumulator width in bits; legal range 5..16.

- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a burst; sampled only in IDLE.
- in_valid  in  1  in_data is valid.
- in_data  in  4  signed two's-complement sample (-8..+7), driven by the negator output.
- in_ready  out  1  block accepts a sample this cycle.
- out_valid  out  1  acc_out and sat are valid.
- out_ready  in  1  downstream takes the result.
- acc_out  out  ACC_W  signed burst sum.
- sat  out  1  sticky flag; at least one add in this burst saturated.

## Operation
- **Reset (rst_n=0, asynchronous).**
  - State goes to IDLE.
  - acc_out, sample count, sat, in_ready and out_valid all go to 0.
  - Reset asserted in the middle of a burst discards the burst.
- **IDLE.**
  - in_ready=0 and out_valid=0.
  - When start=1: on that edge, acc_out←0, count←0, sat←0, and state goes to ACC.
- **ACC.**
  - in_ready=1 and out_valid=0.
  - A sample is accepted when in_valid=1 and in_ready=1 on an edge.
  - On acceptance, compute sum = acc_out + sign_extend(in_data) at ACC_W+1 bits.
  - If sum > 2^(ACC_W-1)-1, acc_out←2^(ACC_W-1)-1 and sat←1.
  - If sum < -2^(ACC_W-1), acc_out←-2^(ACC_W-1) and sat←1.
  - Otherwise acc_out←sum[ACC_W-1:0].
  - Then count←count+1. If that sample was count==N_SAMPLES-1, state goes to DONE.
  - Cycles with in_valid=0 are stalls; all state holds.
  - start is ignored in ACC.
- **DONE.**
  - out_valid=1 and in_ready=0. acc_out and sat are held stable.
  - When out_ready=1 on an edge, state goes to IDLE and out_valid drops on the next cycle.
  - acc_out and sat keep their values in IDLE until the next start.
  - start is ignored in DONE.
  - start=1 in the same cycle as the out_ready handshake is also ignored; the next start must come while in IDLE.
- **Saturation rules.**
  - Saturation is evaluated per add, not at the end of the burst.
  - Once clamped, later samples keep adding from the clamped value. Example: 127 then -1 gives 126.
  - sat never clears within a burst.

## Timing
- in_ready is a registered function of state.
- in_ready rises the cycle after the start edge.
- in_ready falls in the cycle after the last accept.
- out_valid rises in the same cycle in_ready falls.
- Minimum latency:
  - From start edge to first possible accept: 1 cycle.
  - From last accept edge to out_valid=1: 1 cycle.
  - From start edge to out_valid: N_SAMPLES+1 cycles with no stalls.
  - From out_ready edge to the next accepted start: 1 cycle.
- acc_out updates on the accept edge. Intermediate values are visible on acc_out while in ACC but are meaningful only when out_valid=1.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Test plan
- **Reset values.** Defaults. Assert rst_n=0 mid-ACC after 2 accepts -> immediately in_ready=0, out_valid=0, acc_out=0, sat=0. After release, state is IDLE, and a new start runs a clean burst.
- **Negative sum, no stalls.** Defaults. start, then 4'b1111 ×4 back-to-back -> out_valid=1 exactly 1 cycle after the 4th accept, acc_out=8'hFC (-4), sat=0.
- **Stalls and backpressure.** Defaults. Samples +7, -8, +3, -2, with in_valid=0 for 3 cycles between each. Hold out_ready=0 for 5 cycles after out_valid. -> acc_out=8'h00, held stable while out_valid=1. IDLE is entered 1 cycle after out_ready=1.
- **Positive saturation.** N_SAMPLES=20. Twenty samples of 4'b0111 -> acc_out=8'h7F, sat=1. Same run with the last sample replaced by 4'b1111 -> acc_out=8'h7E, sat=1.
- **Negative saturation.** N_SAMPLES=20. Twenty samples of 4'b1000 -> acc_out=8'h80, sat=1.
- **Ignored inputs.** Pulse start during ACC and during DONE -> no effect on count or acc. in_valid=1 in IDLE or DONE -> nothing accepted. A single burst of N_SAMPLES=1 with 4'b1010 -> acc_out=8'hFA.
